mycpu_iodev: RTL and testbench
==============================

MYCPU_IODEV -- requirements
Module: mycpu_iodev

Interface
REQ-001 SHALL have parameter IO_BASE, default 16'h0000, I/O-space base address (bits [2:0] ignored).
REQ-002 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port a_in  input  16  CPU address (from CPU a_out).
REQ-005 SHALL have port d_in  input  16  CPU write data (from CPU d_out).
REQ-006 SHALL have port wen_in  input  1  CPU write enable (from CPU wen_out).
REQ-007 SHALL have port iom_in  input  1  CPU space select, 1 = I/O, 0 = memory (from CPU iom_out).
REQ-008 SHALL have port d_out  output  16  read data to CPU io_in.
REQ-009 SHALL have port gpio_in  input  16  external asynchronous inputs.
REQ-010 SHALL have port gpio_out  output  16  external outputs.
REQ-011 SHALL have port irq  output  1  timer interrupt request.

Function
REQ-012 SHALL select when iom_in=1 and a_in[15:3]==IO_BASE[15:3]; offset = a_in[2:0].
REQ-013 SHALL map offsets: 0 OUT (RW), 1 IN (RO), 2 TCTRL (RW, bit0 EN, bit1 RELOAD, bit2 IE, others read 0), 3 TLOAD (RW), 4 TCOUNT (RO), 5 TSTAT (bit0 EXP, write-1-to-clear), 6-7 reserved.
REQ-014 SHALL return d_out combinationally in the same cycle as address; 16'h0000 when not selected, for reserved offsets, and for unused register bits.
REQ-015 SHALL commit writes on the rising edge with select and wen_in=1; writes to RO/reserved offsets, to memory space, or outside the IO_BASE window have no effect.
REQ-016 SHALL drive gpio_out directly from OUT register.
REQ-017 SHALL pass gpio_in through a 2-flop synchronizer; IN reads the second stage, so a gpio_in change becomes readable 2 clocks later.
REQ-018 SHALL implement TCOUNT as a 16-bit down counter: when EN=1 and TCOUNT!=0, decrement by 1 per clock.
REQ-019 SHALL, when EN=1 and TCOUNT==0: set EXP; if RELOAD=1 load TCOUNT from TLOAD and keep EN=1; if RELOAD=0 hold TCOUNT at 0 and clear EN.
REQ-020 SHALL, on a TLOAD write, also load TCOUNT with the written value in the same edge, overriding decrement/reload in that cycle.
REQ-021 SHALL give precedence to expiry set over a simultaneous TSTAT write-1-to-clear (EXP stays 1).
REQ-022 SHALL, when a TCTRL write and a one-shot auto-clear of EN coincide, apply the written TCTRL value.
REQ-023 SHALL drive irq = EXP & IE, registered-state derived, no combinational path from CPU inputs.
REQ-024 SHALL treat TLOAD=0 with RELOAD=1 as expiry every clock while EN=1.

Reset
REQ-025 SHALL on rst_n=0 asynchronously clear OUT, TCTRL, TLOAD, TCOUNT, EXP and both synchronizer stages to 0; gpio_out=0, irq=0 immediately.
REQ-026 SHALL, if reset asserts mid-count, abandon the count; after release the timer stays idle until software sets EN.

Verification
REQ-027 SHALL cover: write OUT=16'hA5A5 at IO_BASE+0 -> gpio_out=16'hA5A5 next edge; same write with iom_in=0 -> gpio_out unchanged.
REQ-028 SHALL cover: gpio_in steps 16'h0000->16'h1234 -> IN reads 0 for 1 clock, 16'h1234 from the 2nd edge onward.
REQ-029 SHALL cover: TLOAD=3, TCTRL=3'b101 (one-shot, IE) -> TCOUNT 3,2,1,0, then EXP=1, irq=1, EN=0, TCOUNT held 0; write TSTAT=1 -> irq=0.
REQ-030 SHALL cover: TLOAD=2, TCTRL=3'b011 -> TCOUNT 2,1,0,2,1,0..., EXP set every 3 clocks, irq stays 0 (IE=0).
REQ-031 SHALL cover: TSTAT write-1 in the same cycle as expiry -> EXP remains 1; reserved offset 6 read -> 16'h0000.
REQ-032 SHALL cover: rst_n pulled low while TCOUNT=16'h0100 counting -> all registers 0 asynchronously, irq=0, no counting after release.

Source files
------------

// File: rtl/mycpu_iodev_if.sv
// CPU-side I/O bus bundle for mycpu_iodev: address, write data, strobes and read-back data.
// Both ends of the bus (CPU model and device wrapper) connect through the modports below.
interface mycpu_iodev_if;
  logic [15:0] a_in;
  logic [15:0] d_in;
  logic        wen_in;
  logic        iom_in;
  logic [15:0] d_out;

  modport master (
    output a_in,
    output d_in,
    output wen_in,
    output iom_in,
    input  d_out
  );

  modport slave (
    input  a_in,
    input  d_in,
    input  wen_in,
    input  iom_in,
    output d_out
  );
endinterface

// File: rtl/mycpu_iodev.sv
// Small I/O device for mycpu: GPIO out/in registers plus a 16-bit down-counting timer with interrupt.
// Eight-word window in I/O space at IO_BASE; reads are combinational, writes commit on the clock edge.
module mycpu_iodev #(
  parameter logic [15:0] IO_BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a_in,
  input  logic [15:0] d_in,
  input  logic        wen_in,
  input  logic        iom_in,
  output logic [15:0] d_out,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  output logic        irq
);

  typedef enum logic [2:0] {
    OFF_OUT    = 3'd0,
    OFF_IN     = 3'd1,
    OFF_TCTRL  = 3'd2,
    OFF_TLOAD  = 3'd3,
    OFF_TCOUNT = 3'd4,
    OFF_TSTAT  = 3'd5,
    OFF_RSV6   = 3'd6,
    OFF_RSV7   = 3'd7
  } io_off_e;

  typedef struct packed {
    logic ie;
    logic reload;
    logic en;
  } tctrl_t;

  logic [15:0] out_q,    out_d;
  logic [15:0] sync1_q,  sync1_d;
  logic [15:0] sync2_q,  sync2_d;
  tctrl_t      tctrl_q,  tctrl_d;
  logic [15:0] tload_q,  tload_d;
  logic [15:0] tcount_q, tcount_d;
  logic        exp_q,    exp_d;

  logic    sel;
  logic    wr;
  logic    expire;
  io_off_e off;

  assign off    = io_off_e'(a_in[2:0]);
  assign sel    = iom_in && (a_in[15:3] == IO_BASE[15:3]);
  assign wr     = sel && wen_in;
  assign expire = tctrl_q.en && (tcount_q == 16'h0000);

  // Read mux: unused register bits and reserved offsets read back as zero.
  always_comb begin
    d_out = 16'h0000;
    if (sel) begin
      case (off)
        OFF_OUT:    d_out = out_q;
        OFF_IN:     d_out = sync2_q;
        OFF_TCTRL:  d_out = {13'd0, tctrl_q};
        OFF_TLOAD:  d_out = tload_q;
        OFF_TCOUNT: d_out = tcount_q;
        OFF_TSTAT:  d_out = {15'd0, exp_q};
        default:    d_out = 16'h0000;
      endcase
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    out_d    = out_q;
    sync1_d  = gpio_in;
    sync2_d  = sync1_q;
    tctrl_d  = tctrl_q;
    tload_d  = tload_q;
    tcount_d = tcount_q;
    exp_d    = exp_q;

    if (tctrl_q.en) begin
      if (!expire) begin
        tcount_d = tcount_q - 16'd1;
      end else if (tctrl_q.reload) begin
        tcount_d = tload_q;
      end else begin
        tctrl_d.en = 1'b0;
      end
    end

    // Software writes come after the timer update so they override it in the same edge.
    if (wr) begin
      case (off)
        OFF_OUT:   out_d = d_in;
        OFF_TCTRL: tctrl_d = tctrl_t'(d_in[2:0]);
        OFF_TLOAD: begin
          tload_d  = d_in;
          tcount_d = d_in;
        end
        OFF_TSTAT: if (d_in[0]) exp_d = 1'b0;
        default: ;
      endcase
    end

    // Expiry wins over a coincident write-1-to-clear.
    if (expire) begin
      exp_d = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  // NOTE: every register, synchronizer stages included, is cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= 16'h0000;
      sync1_q  <= 16'h0000;
      sync2_q  <= 16'h0000;
      tctrl_q  <= '0;
      tload_q  <= 16'h0000;
      tcount_q <= 16'h0000;
      exp_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      tctrl_q  <= tctrl_d;
      tload_q  <= tload_d;
      tcount_q <= tcount_d;
      exp_q    <= exp_d;
    end
  end

  assign gpio_out = out_q;
  assign irq      = exp_q & tctrl_q.ie;

endmodule

// File: tb/tb_mycpu_iodev.sv
// Self-checking bench for mycpu_iodev: directed scenarios followed by random bus traffic,
// all compared against a register-level behavioural model of the device.
module tb_mycpu_iodev;

  localparam logic [15:0] BASE = 16'hC00D;
  localparam logic [15:0] WIN  = 16'hC008;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq;

  mycpu_iodev_if bus();

  mycpu_iodev #(.IO_BASE(BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_in     (bus.a_in),
    .d_in     (bus.d_in),
    .wen_in   (bus.wen_in),
    .iom_in   (bus.iom_in),
    .d_out    (bus.d_out),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Behavioural model of the programmer-visible state.
  logic [15:0] m_out, m_s1, m_s2, m_tload, m_tcnt;
  logic        m_en, m_rl, m_ie, m_exp;

  logic [15:0] seq30 [9];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_s1 = 0; m_s2 = 0; m_tload = 0; m_tcnt = 0;
    m_en = 0; m_rl = 0; m_ie = 0; m_exp = 0;
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] off);
    case (off)
      3'd0:    return m_out;
      3'd1:    return m_s2;
      3'd2:    return {13'd0, m_ie, m_rl, m_en};
      3'd3:    return m_tload;
      3'd4:    return m_tcnt;
      3'd5:    return {15'd0, m_exp};
      default: return 16'h0000;
    endcase
  endfunction

  // Advance the model by one clock using the bus/gpio inputs presented at the edge.
  task automatic model_step();
    logic        hit, fire;
    logic [2:0]  off;
    logic [15:0] d;
    logic [15:0] n_out, n_tl, n_tc;
    logic        n_en, n_rl, n_ie, n_exp;
    hit  = bus.iom_in && bus.wen_in && ((bus.a_in & 16'hFFF8) == WIN);
    off  = bus.a_in[2:0];
    d    = bus.d_in;
    fire = m_en && (m_tcnt == 0);
    n_out = m_out; n_tl = m_tload; n_tc = m_tcnt;
    n_en = m_en; n_rl = m_rl; n_ie = m_ie; n_exp = m_exp;
    if (m_en && m_tcnt != 0) n_tc = m_tcnt - 16'd1;
    if (fire) begin
      n_exp = 1;
      if (m_rl) n_tc = m_tload;
      else      n_en = 0;
    end
    if (hit) begin
      case (off)
        3'd0: n_out = d;
        3'd2: begin n_en = d[0]; n_rl = d[1]; n_ie = d[2]; end
        3'd3: begin n_tl = d; n_tc = d; end
        3'd5: if (d[0] && !fire) n_exp = 0;
        default: ;
      endcase
    end
    m_s2 = m_s1; m_s1 = gpio_in;
    m_out = n_out; m_tload = n_tl; m_tcnt = n_tc;
    m_en = n_en; m_rl = n_rl; m_ie = n_ie; m_exp = n_exp;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic [15:0] a, input logic [15:0] d, input logic w, input logic iom);
    bus.a_in = a; bus.d_in = d; bus.wen_in = w; bus.iom_in = iom;
  endtask

  task automatic wr(input logic [2:0] off, input logic [15:0] d);
    set_bus(WIN | {13'd0, off}, d, 1'b1, 1'b1);
    tick();
    set_bus(WIN, 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic rd(input string tag, input logic [2:0] off, input logic [15:0] exp);
    set_bus(WIN | {13'd0, off}, 16'h0000, 1'b0, 1'b1);
    #1;
    check(tag, bus.d_out, exp);
  endtask

  initial begin
    seq30 = '{16'd1, 16'd0, 16'd2, 16'd1, 16'd0, 16'd2, 16'd1, 16'd0, 16'd2};
    rst_n   = 1'b0;
    gpio_in = 16'h0000;
    set_bus(WIN, 16'h0000, 1'b0, 1'b1);
    model_reset();
    #15;
    check("rst_gpio_out", gpio_out, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'h0000);
    for (int i = 0; i < 8; i++) rd("rst_reg", 3'(i), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // OUT write, then the same write from memory space and from outside the window.
    wr(3'd0, 16'hA5A5);
    check("out_write", gpio_out, 16'hA5A5);
    set_bus(WIN, 16'h5A5A, 1'b1, 1'b0);
    tick();
    check("out_mem_space", gpio_out, 16'hA5A5);
    set_bus(WIN + 16'h0010, 16'h5A5A, 1'b1, 1'b1);
    tick();
    check("out_outside", gpio_out, 16'hA5A5);
    rd("out_read", 3'd0, 16'hA5A5);

    // Input synchronizer latency.
    gpio_in = 16'h1234;
    rd("in_edge0", 3'd1, 16'h0000);
    tick();
    rd("in_edge1", 3'd1, 16'h0000);
    tick();
    rd("in_edge2", 3'd1, 16'h1234);

    // One-shot with interrupt enabled.
    wr(3'd3, 16'd3);
    wr(3'd2, 16'h0005);
    rd("os_cnt3", 3'd4, 16'd3);
    tick(); rd("os_cnt2", 3'd4, 16'd2);
    tick(); rd("os_cnt1", 3'd4, 16'd1);
    tick(); rd("os_cnt0", 3'd4, 16'd0);
    check("os_irq_pre", {15'd0, irq}, 16'h0000);
    tick();
    check("os_irq", {15'd0, irq}, 16'h0001);
    rd("os_exp", 3'd5, 16'h0001);
    rd("os_en_clr", 3'd2, 16'h0004);
    tick();
    rd("os_hold0", 3'd4, 16'd0);
    wr(3'd5, 16'h0001);
    check("os_irq_clr", {15'd0, irq}, 16'h0000);
    rd("os_exp_clr", 3'd5, 16'h0000);

    // Auto-reload, interrupt disabled.
    wr(3'd3, 16'd2);
    wr(3'd2, 16'h0003);
    rd("rl_start", 3'd4, 16'd2);
    for (int i = 0; i < 9; i++) begin
      tick();
      rd("rl_cnt", 3'd4, seq30[i]);
      check("rl_irq", {15'd0, irq}, 16'h0000);
      if (i == 2) rd("rl_exp", 3'd5, 16'h0001);
    end

    // Clear away from expiry, then clear coinciding with expiry.
    wr(3'd5, 16'h0001);
    rd("w1c_normal", 3'd5, 16'h0000);
    tick();
    rd("w1c_cnt0", 3'd4, 16'd0);
    wr(3'd5, 16'h0001);
    rd("w1c_vs_exp", 3'd5, 16'h0001);
    rd("rsv6", 3'd6, 16'h0000);
    rd("rsv7", 3'd7, 16'h0000);
    wr(3'd6, 16'hFFFF);
    rd("rsv6_wr", 3'd6, 16'h0000);
    rd("out_after_rsv", 3'd0, model_read(3'd0));

    // TLOAD=0 with reload: expiry on every clock.
    wr(3'd3, 16'd0);
    for (int i = 0; i < 3; i++) begin
      wr(3'd5, 16'h0001);
      rd("z_exp", 3'd5, 16'h0001);
      rd("z_cnt", 3'd4, 16'd0);
      rd("z_ctrl", 3'd2, 16'h0003);
    end

    // TCTRL write coinciding with one-shot auto-clear.
    wr(3'd2, 16'h0000);
    wr(3'd3, 16'd1);
    wr(3'd5, 16'h0001);
    wr(3'd2, 16'h0001);
    tick();
    rd("co_cnt0", 3'd4, 16'd0);
    wr(3'd2, 16'h0007);
    rd("co_ctrl", 3'd2, 16'h0007);
    rd("co_cnt", 3'd4, 16'd0);
    check("co_irq", {15'd0, irq}, 16'h0001);
    tick();
    rd("co_reload", 3'd4, 16'd1);

    // TLOAD write while counting, then asynchronous reset mid-count.
    wr(3'd3, 16'h0100);
    rd("tl_override", 3'd4, 16'h0100);
    tick();
    rd("tl_count", 3'd4, 16'h00FF);
    check("pre_rst_irq", {15'd0, irq}, 16'h0001);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_gpio_out", gpio_out, 16'h0000);
    check("arst_irq", {15'd0, irq}, 16'h0000);
    for (int i = 0; i < 6; i++) rd("arst_reg", 3'(i), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      rd("post_rst_cnt", 3'd4, 16'h0000);
      rd("post_rst_ctrl", 3'd2, 16'h0000);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  ro, wo;
      logic [15:0] a, d;
      int          kind;
      ro = 3'($urandom_range(0, 7));
      rd("rand_rd", ro, model_read(ro));
      if ($urandom_range(0, 3) == 0) gpio_in = 16'($urandom);
      kind = $urandom_range(0, 9);
      wo = 3'($urandom_range(0, 7));
      d  = (wo == 3'd3) ? 16'($urandom_range(0, 6)) : 16'($urandom);
      if (kind <= 5) begin
        set_bus(WIN | {13'd0, wo}, d, 1'b1, 1'b1);
      end else if (kind == 6) begin
        set_bus(WIN | {13'd0, wo}, d, 1'b1, 1'b0);
      end else if (kind == 7) begin
        a = 16'($urandom);
        if ((a & 16'hFFF8) == WIN) a = a ^ 16'h0100;
        set_bus(a, d, 1'b1, 1'b1);
      end else begin
        set_bus(WIN, d, 1'b0, 1'b1);
      end
      tick();
      set_bus(WIN, 16'h0000, 1'b0, 1'b1);
      check("rand_gpio_out", gpio_out, m_out);
      check("rand_irq", {15'd0, irq}, {15'd0, m_exp & m_ie});
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
